// File: rtl/float_pkg.sv
// Shared definitions for the floating-point multiplier datapath.
// Contents:
//   - rnd_mode_e : rounding-mode constants (RND_TRUNC, RND_NEAR).
//   - bias()     : exponent bias for an EXP_W-bit exponent field.
//   - word_width(): packed operand width {sign, exp, man}.
//   - sign_bit(), exp_field(), man_field(): field extractors that work on
//     a zero-extended packed word, so one set of helpers serves any widths.
package float_pkg;

  localparam int unsigned FIELD_W = 64;
  typedef logic [FIELD_W-1:0] field_t;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_NEAR  = 1'b1
  } rnd_mode_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int word_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic logic sign_bit(input field_t w, input int exp_w, input int man_w);
    return w[exp_w + man_w];
  endfunction

  function automatic field_t exp_field(input field_t w, input int exp_w, input int man_w);
    return (w >> man_w) & ((field_t'(1) << exp_w) - field_t'(1));
  endfunction

  function automatic field_t man_field(input field_t w, input int man_w);
    return w & ((field_t'(1) << man_w) - field_t'(1));
  endfunction

endpackage

// File: rtl/fp_mant_mult.sv
// Unsigned MW x MW mantissa multiplier with a single output register and a
// clock enable. Kept as its own block so a vendor multiplier macro can be
// dropped in; it carries no valid state of its own.
// Ports:
//   clk_i  - clock
//   en_i   - register enable (the owner's stage-1 load)
//   a_i    - multiplicand, hidden bit included
//   b_i    - multiplier, hidden bit included
//   p_o    - registered 2*MW-bit product
module fp_mant_mult #(
  parameter int MW = 7
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic [MW-1:0]   a_i,
  input  logic [MW-1:0]   b_i,
  output logic [2*MW-1:0] p_o
);

  // NOTE: pure datapath register -- no reset; qualifying valid bits live in the owner.
  always_ff @(posedge clk_i) begin
    if (en_i) p_o <= {{MW{1'b0}}, a_i} * {{MW{1'b0}}, b_i};
  end

endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control and bubble collapsing. No denormals, infinities or NaNs: a zero
// exponent field means zero, the all-ones exponent is an ordinary value.
// Out-of-range results saturate (ovf_o) or flush to +0 (unf_o).
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   in_valid_i / in_ready_o   - operand handshake
//   data_a_i, data_b_i        - operands {sign, exp, man}
//   rnd_mode_i                - 0 truncate, 1 round-to-nearest ties away
//   tag_i                     - sideband tag, travels with the operands
//   out_valid_o / out_ready_i - result handshake
//   data_mult_o, tag_o        - product and its tag
//   ovf_o, unf_o              - saturated / flushed-to-zero flags
module float_mult_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6,
  parameter int TAG_W = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [word_width(EXP_W, MAN_W)-1:0] data_a_i,
  input  logic [word_width(EXP_W, MAN_W)-1:0] data_b_i,
  input  logic                                rnd_mode_i,
  input  logic [TAG_W-1:0]                    tag_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [word_width(EXP_W, MAN_W)-1:0] data_mult_o,
  output logic [TAG_W-1:0]                    tag_o,
  output logic                                ovf_o,
  output logic                                unf_o
);

  localparam int W  = word_width(EXP_W, MAN_W);
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;   // signed headroom for sum, +1 and rounding carry
  localparam logic signed [EW-1:0] BIAS_S    = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);

  // ---------------------------------------------------------------- flow
  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic ld1, ld2, ld3;

  // A stage may take new content when it is empty or its content leaves.
  assign adv3 = ~v3 | out_ready_i;
  assign adv2 = ~v2 | adv3;
  assign adv1 = ~v1 | adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = v3;

  // Data registers load only on a real transfer, so a held result stays put.
  assign ld1 = in_valid_i & adv1;
  assign ld2 = v1 & adv2;
  assign ld3 = v2 & adv3;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid_i;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  // ---------------------------------------------------------------- S1
  field_t           a_w, b_w;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign a_w = field_t'(data_a_i);
  assign b_w = field_t'(data_b_i);
  assign ea  = EXP_W'(exp_field(a_w, EXP_W, MAN_W));
  assign eb  = EXP_W'(exp_field(b_w, EXP_W, MAN_W));
  assign ma  = MAN_W'(man_field(a_w, MAN_W));
  assign mb  = MAN_W'(man_field(b_w, MAN_W));

  logic                 s1_sign, s1_zero;
  rnd_mode_e            s1_rnd;
  logic [TAG_W-1:0]     s1_tag;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clk_i) begin
    if (ld1) begin
      s1_sign <= sign_bit(a_w, EXP_W, MAN_W) ^ sign_bit(b_w, EXP_W, MAN_W);
      s1_zero <= (ea == '0) | (eb == '0);
      s1_rnd  <= rnd_mode_e'(rnd_mode_i);
      s1_tag  <= tag_i;
      s1_exp  <= $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS_S;
    end
  end

  fp_mant_mult #(.MW(MW)) u_mant_mult (
    .clk_i (clk_i),
    .en_i  (ld1),
    .a_i   ({1'b1, ma}),
    .b_i   ({1'b1, mb}),
    .p_o   (s1_prod)
  );

  // ---------------------------------------------------------------- S2
  logic signed [EW-1:0] s2_exp_n;
  logic [MAN_W-1:0]     s2_frac_n;
  logic                 s2_guard_n;
  logic                 prod_unused;

  // Bits below the guard never influence the result (no sticky bit).
  assign prod_unused = ^s1_prod[MAN_W-2:0];

  // NOTE: defaults assigned first in every always_comb so no path can infer a latch.
  always_comb begin
    s2_exp_n   = s1_exp;
    s2_frac_n  = s1_prod[PW-3 -: MAN_W];
    s2_guard_n = s1_prod[PW-3-MAN_W];
    if (s1_prod[PW-1]) begin
      // Product in [2,4): shift right one place, bump the exponent.
      s2_exp_n   = s1_exp + EW'(1);
      s2_frac_n  = s1_prod[PW-2 -: MAN_W];
      s2_guard_n = s1_prod[PW-2-MAN_W];
    end
  end

  logic                 s2_sign, s2_zero, s2_guard;
  rnd_mode_e            s2_rnd;
  logic [TAG_W-1:0]     s2_tag;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;

  always_ff @(posedge clk_i) begin
    if (ld2) begin
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_rnd   <= s1_rnd;
      s2_tag   <= s1_tag;
      s2_exp   <= s2_exp_n;
      s2_frac  <= s2_frac_n;
      s2_guard <= s2_guard_n;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [MAN_W:0]       rnd_sum;
  logic [MAN_W-1:0]     fin_frac;
  logic signed [EW-1:0] fin_exp;
  logic [W-1:0]         res_word;
  logic                 res_ovf, res_unf;

  always_comb begin
    rnd_sum  = {1'b0, s2_frac} + (MAN_W+1)'(s2_guard);
    fin_frac = s2_frac;
    fin_exp  = s2_exp;
    if (s2_rnd == RND_NEAR) begin
      // On carry-out the low bits of rnd_sum are already zero.
      fin_frac = rnd_sum[MAN_W-1:0];
      if (rnd_sum[MAN_W]) fin_exp = s2_exp + EW'(1);
    end

    res_word = {s2_sign, fin_exp[EXP_W-1:0], fin_frac};
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (s2_zero) begin
      res_word = '0;
    end else if (fin_exp > EXP_MAX_S) begin
      res_word = {s2_sign, {(W-1){1'b1}}};
      res_ovf  = 1'b1;
    end else if (fin_exp <= EW'(0)) begin
      res_word = '0;
      res_unf  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_mult_o <= '0;
      tag_o       <= '0;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
    end else if (ld3) begin
      data_mult_o <= res_word;
      tag_o       <= s2_tag;
      ovf_o       <= res_ovf;
      unf_o       <= res_unf;
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Self-checking bench for float_mult_pipe at EXP_W=5, MAN_W=6, TAG_W=4.
// Expected results come from a value-level reference model: the exact
// integer mantissa product is scaled until it fits the stored precision,
// then rounded, range-checked and packed.
module tb_float_mult_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 6;
  localparam int TAG_W = 4;
  localparam int W     = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic [W-1:0]     res;
    logic             ovf;
    logic             unf;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [W-1:0] r;
    logic         ovf;
    logic         unf;
  } vec_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [W-1:0]     data_a_i = '0;
  logic [W-1:0]     data_b_i = '0;
  logic             rnd_mode_i = 1'b0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [W-1:0]     data_mult_o;
  logic [TAG_W-1:0] tag_o;
  logic             ovf_o, unf_o;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  float_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_a_i    (data_a_i),
    .data_b_i    (data_b_i),
    .rnd_mode_i  (rnd_mode_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_mult_o (data_mult_o),
    .tag_o       (tag_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o)
  );

  // Reference: value = 1.m * 2^(e-15). Scale the exact product down by k
  // bits until it holds 7 significant bits (hidden 1 + 6 stored).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic mode, input logic [TAG_W-1:0] tag);
    int     ea, eb, e, k, bias_v;
    longint p, frac, g;
    logic   s;
    exp_t   r;
    bias_v = 15;
    ea = int'(a[10:6]);
    eb = int'(b[10:6]);
    r.tag = tag;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.res = '0;
    if (ea == 0 || eb == 0) return r;
    s = a[11] ^ b[11];
    p = longint'(64 + int'(a[5:0])) * longint'(64 + int'(b[5:0]));
    k = 0;
    while ((p >> k) >= 128) k++;
    frac = p >> k;
    g    = (p >> (k - 1)) & 1;
    e    = ea + eb - bias_v + (k - 6);
    if (mode) begin
      frac = frac + g;
      if (frac == 128) begin
        frac = 64;
        e    = e + 1;
      end
    end
    if (e > 31) begin
      r.res = {s, 11'h7FF};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.res = {s, e[4:0], frac[5:0]};
    end
    return r;
  endfunction

  // Apply one cycle of inputs at the falling edge, then settle.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mode, input logic [TAG_W-1:0] tag, input logic rdy);
    @(negedge clk_i);
    in_valid_i  = v;
    data_a_i    = a;
    data_b_i    = b;
    rnd_mode_i  = mode;
    tag_i       = tag;
    out_ready_i = rdy;
    #1;
  endtask

  // Send one transaction into an empty pipeline and collect its result.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                         input logic [TAG_W-1:0] tag, output exp_t got, output int lat);
    drive(1'b1, a, b, mode, tag, 1'b1);
    lat = -1;
    got = 'x;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, a, b, mode, tag, 1'b1);
      if (out_valid_o === 1'b1) begin
        lat = i;
        got = {data_mult_o, ovf_o, unf_o, tag_o};
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", out_valid_o); end
    checks++; if (data_mult_o !== '0) begin errors++; $display("FAIL reset data got=%h exp=000", data_mult_o); end
    checks++; if (tag_o !== '0) begin errors++; $display("FAIL reset tag got=%h exp=0", tag_o); end
    checks++; if ({ovf_o, unf_o} !== 2'b00) begin errors++; $display("FAIL reset flags got=%b%b exp=00", ovf_o, unf_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    exp_t got;
    int   lat;
    foreach (tbl[i]) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].mode, TAG_W'(i + 3), got, lat);
      checks++;
      if (got !== {tbl[i].r, tbl[i].ovf, tbl[i].unf, TAG_W'(i + 3)}) begin
        errors++;
        $display("FAIL %s[%0d] %h*%h got res=%h ovf=%b unf=%b tag=%h exp res=%h ovf=%b unf=%b tag=%h",
                 name, i, tbl[i].a, tbl[i].b, got.res, got.ovf, got.unf, got.tag,
                 tbl[i].r, tbl[i].ovf, tbl[i].unf, TAG_W'(i + 3));
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL %s[%0d] latency got=%0d exp=3", name, i, lat); end
    end
  endtask

  task automatic test_basic();
    vec_t t[$];
    t.push_back('{12'h3C0, 12'h3C0, 1'b0, 12'h3C0, 1'b0, 1'b0});
    t.push_back('{12'h3E0, 12'h3E0, 1'b0, 12'h408, 1'b0, 1'b0});
    t.push_back('{12'hC00, 12'h3E0, 1'b0, 12'hC20, 1'b0, 1'b0});
    run_table("basic", t);
  endtask

  task automatic test_rounding();
    vec_t t[$];
    t.push_back('{12'h3C1, 12'h3E0, 1'b0, 12'h3E1, 1'b0, 1'b0});
    t.push_back('{12'h3C1, 12'h3E0, 1'b1, 12'h3E2, 1'b0, 1'b0});
    run_table("round", t);
  endtask

  task automatic test_boundaries();
    vec_t t[$];
    t.push_back('{12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 1'b1, 1'b0});
    t.push_back('{12'h040, 12'h040, 1'b0, 12'h000, 1'b0, 1'b1});
    t.push_back('{12'h000, 12'h7FF, 1'b0, 12'h000, 1'b0, 1'b0});
    run_table("bound", t);
  endtask

  // Eight tagged pairs, consumer stalled for cycles 4..8.
  task automatic test_back_to_back();
    int           sent, got_n, inflight;
    logic         held;
    exp_t         hold_v, e, obs;
    logic [W-1:0] a, b;
    sent = 0; got_n = 0; inflight = 0; held = 1'b0; hold_v = '0;
    for (int t = 0; t < 60 && got_n < 8; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      drive(sent < 8, a, b, 1'b0, TAG_W'(sent), !(t >= 4 && t <= 8));
      obs = {data_mult_o, ovf_o, unf_o, tag_o};
      checks++;
      if (in_ready_o !== ((inflight < 3) || out_ready_i)) begin
        errors++;
        $display("FAIL bp in_ready t=%0d got=%b exp=%b", t, in_ready_o, (inflight < 3) || out_ready_i);
      end
      if (held) begin
        checks++;
        if (out_valid_o !== 1'b1 || obs !== hold_v) begin
          errors++;
          $display("FAIL bp hold t=%0d got v=%b %h exp v=1 %h", t, out_valid_o, obs, hold_v);
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL bp extra output t=%0d got %h exp none", t, obs);
        end else begin
          e = sb_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL bp data t=%0d got %h exp %h", t, obs, e); end
        end
        got_n++; inflight--;
      end
      held   = out_valid_o && !out_ready_i;
      hold_v = obs;
      if (in_valid_i && in_ready_o) begin
        sb_q.push_back(model(a, b, 1'b0, TAG_W'(sent)));
        sent++; inflight++;
      end
    end
    checks++;
    if (got_n != 8 || sb_q.size() != 0) begin
      errors++; $display("FAIL bp count got=%0d exp=8 left=%0d", got_n, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Mostly alternating valids, random back-pressure, random modes.
  task automatic test_bubbles();
    int           sent, mism;
    exp_t         e, obs;
    logic [W-1:0] a, b;
    logic         mode, v;
    logic [TAG_W-1:0] tag;
    sent = 0; mism = 0;
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || sb_q.size() > 0); cyc++) begin
      a = W'($urandom); b = W'($urandom);
      mode = 1'($urandom_range(0, 1));
      tag  = TAG_W'($urandom);
      v = (sent < 10000) && ((cyc % 2 == 0) || ($urandom_range(0, 3) == 0));
      drive(v, a, b, mode, tag, $urandom_range(0, 3) != 0);
      if (out_valid_o && out_ready_i) begin
        obs = {data_mult_o, ovf_o, unf_o, tag_o};
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rand extra output cyc=%0d got %h exp none", cyc, obs);
        end else begin
          e = sb_q.pop_front();
          if (obs !== e && mism < 10) begin
            mism++; $display("FAIL rand cyc=%0d got %h exp %h", cyc, obs, e);
          end
          if (obs !== e) errors++;
        end
      end
      if (in_valid_i && in_ready_o) begin
        sb_q.push_back(model(a, b, mode, tag));
        sent++;
      end
    end
    checks++;
    if (sent != 10000 || sb_q.size() != 0) begin
      errors++; $display("FAIL rand drain sent=%0d exp=10000 left=%0d", sent, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    exp_t e, obs;
    int   seen, lat;
    for (int i = 0; i < 3; i++) drive(1'b1, 12'h3E0, 12'h3C0, 1'b0, TAG_W'(8 + i), 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1; in_valid_i = 1'b1; tag_i = TAG_W'(11); out_ready_i = 1'b0;
    #1;
    @(negedge clk_i);
    rst_i = 1'b0; in_valid_i = 1'b1; data_a_i = 12'h3E0; data_b_i = 12'h3E0;
    rnd_mode_i = 1'b0; tag_i = TAG_W'(12); out_ready_i = 1'b1;
    #1;
    e = model(12'h3E0, 12'h3E0, 1'b0, TAG_W'(12));
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=%b exp=0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got=%b exp=1", in_ready_o); end
    seen = 0; lat = -1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 12'h000, 12'h000, 1'b0, '0, 1'b1);
      if (out_valid_o) begin
        obs = {data_mult_o, ovf_o, unf_o, tag_o};
        seen++;
        lat = i;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mid emit i=%0d got %h exp %h", i, obs, e); end
      end
    end
    checks++;
    if (seen != 1 || lat != 3) begin
      errors++; $display("FAIL rst_mid count/latency got=%0d/%0d exp=1/3", seen, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_boundaries();
    test_back_to_back();
    test_bubbles();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_mult_pipe.md
# float_mult_pipe

Parametrised, fully pipelined floating-point multiplier with valid/ready flow control. It is the next generation of the team's fixed 12-bit multiplier and adds:
- configurable exponent and mantissa widths;
- selectable rounding mode;
- overflow and underflow status flags;
- a sideband tag;
- stall-safe back-pressure with bubble collapsing.

It sits in the neuron datapath between operand fetch and the accumulator.

## Interface
Parameters:
- EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 6, stored mantissa width (hidden 1 implied).
- TAG_W, 4, sideband tag width, carried unchanged.

Ports. One clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  pipeline can accept.
- data_a_i  in  1+EXP_W+MAN_W  operand A, packed {sign, exp, man}.
- data_b_i  in  1+EXP_W+MAN_W  operand B, same packing.
- rnd_mode_i  in  1  0 = truncate, 1 = round-to-nearest, ties away from zero.
- tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- data_mult_o  out  1+EXP_W+MAN_W  product.
- tag_o  out  TAG_W  tag of the product.
- ovf_o  out  1  result saturated.
- unf_o  out  1  result flushed to zero.

## Operation
Number format:
- An operand is zero iff its exponent field is 0; its mantissa is ignored (no denormals).
- There are no infinities or NaNs. Exponent 2^EXP_W-1 is a normal finite value.

Arithmetic rules:
- Zero operand: result is +0 (all bits 0), ovf=0, unf=0.
- Sign: s = sa ^ sb.
- Product: P = {1,ma} * {1,mb}, width 2*MAN_W+2.
- Normalisation when P[msb] = 1: e = ea + eb - bias + 1; frac = next MAN_W bits; guard = the following bit.
- Normalisation otherwise: e = ea + eb - bias; frac is taken one bit lower; guard = the following bit.
- Rounding, mode 1: add guard to frac. Mantissa carry-out sets frac = 0 and e = e + 1. Mode 0: frac unchanged.
- Exponent width: e is computed signed, EXP_W+2 bits wide.
- Overflow: if e > 2^EXP_W-1 after rounding, output {s, all ones} and set ovf=1.
- Underflow: if e <= 0 after rounding, output +0 and set unf=1.
- rnd_mode_i and tag_i are sampled with the operands and travel with the transaction.

Pipeline stages:
- S1: unpack, sign, exponent sum, zero detect, registered mantissa product.
- S2: normalise, exponent adjust, guard.
- S3: round, saturate/flush, pack.

Flow control:
- Each stage holds a valid bit.
- A stage loads when it is empty or its content moves on that cycle (bubble collapsing).
- S3 moves on when out_ready_i = 1.
- in_ready_o = ~v1 | S1 moves on. This is a combinational chain from out_ready_i.
- An input is accepted when in_valid_i & in_ready_o.
- A held output (out_valid_o & ~out_ready_i) keeps data_mult_o, tag_o and the flags stable.
- Order is preserved; no transaction is dropped or duplicated.

## Timing
- Latency: a transaction accepted in cycle c drives out_valid_o = 1 in cycle c+3 when there is no stall.
- Throughput: one result per cycle while out_ready_i = 1.
- Reset: all stage valids clear. out_valid_o=0, data_mult_o=0, tag_o=0, ovf_o=0, unf_o=0. in_ready_o=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight transaction. It has priority over any simultaneous accept.
- Full pipeline with out_ready_i = 0: in_ready_o = 0 in the same cycle.
- Full pipeline with out_ready_i = 1: in_ready_o = 1, and a simultaneous accept and emit is legal.
- S3 output registers change only on an S3 load.

## Structure
- Shared package float_pkg holds:
  - bias function of EXP_W;
  - rounding-mode constants RND_TRUNC = 0 and RND_NEAR = 1;
  - field-extract helper functions;
  - the packed-word width function 1+EXP_W+MAN_W.
- Sub-module fp_mant_mult: unsigned (MAN_W+1)x(MAN_W+1) multiplier with one register stage and a clock enable, so it can be swapped for a vendor multiplier macro. It holds no valid state; its enable is the S1 load.

## Test plan
Defaults EXP_W=5, MAN_W=6, out_ready_i=1, rounding mode 0 unless stated.
- Basic products:
  - 0x3C0 * 0x3C0 -> 0x3C0.
  - 0x3E0 * 0x3E0 -> 0x408.
  - 0xC00 * 0x3E0 -> 0xC20.
  - All three with flags 0 and out_valid_o in cycle c+3.
- Rounding: 0x3C1 * 0x3E0 -> 0x3E1 with mode 0, 0x3E2 with mode 1.
- Boundaries:
  - 0x7FF * 0x7FF -> 0x7FF, ovf=1.
  - 0x040 * 0x040 -> 0x000, unf=1.
  - 0x000 * 0x7FF -> 0x000, both flags 0.
- Back-pressure: stream 8 tagged pairs (tags 0..7) with out_ready_i low for cycles 4-8.
  - in_ready_o drops once three transactions are held.
  - Outputs stay stable while held.
  - Tags emerge 0..7 in order, with no loss or duplication.
- Bubbles: alternate in_valid_i with out_ready_i toggling randomly; the scoreboard matches a reference model bit-exactly over 10k random operands in both rounding modes.
- Reset: assert rst_i for one cycle with 3 transactions in flight.
  - out_valid_o = 0 the next cycle.
  - None of the 3 is emitted.
  - A new transaction accepted right after reset appears 3 cycles later.
